// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART controller FSM states and parameter defaults
package uart_pkg;

    localparam logic [0:0] S_WAIT = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    localparam int DEPTH_DEF     = 8;
    localparam int ERR_W_DEF     = 8;
    localparam int IDLE_CLKS_DEF = 1024;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous first-word-fall-through byte FIFO
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         push_ok, pop_ok;

    assign o_level = wr_ptr_q - rd_ptr_q;
    assign o_full  = (o_level == (AW+1)'(DEPTH));
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign pop_ok  = i_pop && !o_empty;
    assign push_ok = i_push && (!o_full || pop_ok);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= i_data;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART RX handshake controller, FIFO drain and status (option: UART_RX_CTRL_TIMEOUT_EN)
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ERR_W     = ERR_W_DEF,
    parameter int IDLE_CLKS = IDLE_CLKS_DEF,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_avail,
    input  logic             i_rx_err,
    output logic             o_rx_ack,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [AW:0]      o_level,
    output logic             o_overflow,
    output logic [ERR_W-1:0] o_err_cnt,
    input  logic             i_clr,
    output logic             o_idle
);

    logic [0:0]       state_q, state_d;
    logic             ack_q, ack_d;
    logic             ovf_q, ovf_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             capture, push_byte, err_evt;
    logic             pop, full, empty;

    // Only S_WAIT captures, so a level still high during S_ACK is never taken twice.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (state_q == S_WAIT) begin
            if (i_rx_avail || i_rx_err) begin
                capture = 1'b1;
                state_d = S_ACK;
            end
        end else begin
            if (!i_rx_avail && !i_rx_err) begin
                state_d = S_WAIT;
            end
        end
    end

    assign ack_d     = (state_d == S_ACK);
    assign push_byte = capture && i_rx_avail && !i_rx_err;
    assign err_evt   = capture && i_rx_err;
    assign pop       = !empty && i_ready;

    always_comb begin
        ovf_d     = ovf_q;
        err_cnt_d = err_cnt_q;
        if (i_clr) begin
            ovf_d     = 1'b0;
            err_cnt_d = '0;
        end else begin
            if (push_byte && full && !pop) begin
                ovf_d = 1'b1;
            end
            if (err_evt && (err_cnt_q != {ERR_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_WAIT;
            ack_q     <= 1'b0;
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            ovf_q     <= ovf_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push_byte),
        .i_data  (i_rx_data),
        .i_pop   (pop),
        .o_data  (o_data),
        .o_full  (full),
        .o_empty (empty),
        .o_level (o_level)
    );

    assign o_rx_ack   = ack_q;
    assign o_valid    = !empty;
    assign o_overflow = ovf_q;
    assign o_err_cnt  = err_cnt_q;

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int IDLE_W = $clog2(IDLE_CLKS + 1);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              armed_q, armed_d;
    logic              hit;

    // Counter holds cycles since the last capture; it only runs once a byte has armed it.
    assign hit = armed_q && (idle_cnt_q == IDLE_W'(IDLE_CLKS));

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        armed_d    = armed_q;
        if (capture) begin
            idle_cnt_d = '0;
            if (push_byte) begin
                armed_d = 1'b1;
            end
        end else if (hit) begin
            armed_d = 1'b0;
        end else if (armed_q) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_cnt_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            armed_q    <= armed_d;
        end
    end

    assign o_idle = hit;
`else
    assign o_idle = 1'b0 & (IDLE_CLKS > 0);
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl against a queue-based reference
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int IDLE  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_avail = 1'b0;
    logic       rx_err = 1'b0;
    logic       ready = 1'b0;
    logic       clr = 1'b0;

    logic       a_ack, a_valid, a_ovf, a_idle;
    logic [7:0] a_data, a_err;
    logic [3:0] a_level;
    logic       b_ack, b_valid, b_ovf, b_idle;
    logic [7:0] b_data;
    logic [1:0] b_err;
    logic [3:0] b_level;

    uart_rx_ctrl #(.DEPTH(DEPTH), .ERR_W(8), .IDLE_CLKS(IDLE)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_avail(rx_avail),
        .i_rx_err(rx_err), .o_rx_ack(a_ack), .o_data(a_data), .o_valid(a_valid),
        .i_ready(ready), .o_level(a_level), .o_overflow(a_ovf), .o_err_cnt(a_err),
        .i_clr(clr), .o_idle(a_idle)
    );

    uart_rx_ctrl #(.DEPTH(DEPTH), .ERR_W(2), .IDLE_CLKS(IDLE)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_avail(rx_avail),
        .i_rx_err(rx_err), .o_rx_ack(b_ack), .o_data(b_data), .o_valid(b_valid),
        .i_ready(ready), .o_level(b_level), .o_overflow(b_ovf), .o_err_cnt(b_err),
        .i_clr(clr), .o_idle(b_idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    int         m_err_a = 0;
    int         m_err_b = 0;

    int edge_n = 0;
    int idle_pulses = 0;
    int pulse_edge = -1;
    int cap_edge = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(posedge clk) begin
        #1;
        if (a_idle === 1'b1) begin
            idle_pulses++;
            pulse_edge = edge_n;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_level_a"}, 32'(a_level), q.size());
        chk({tag, "_level_b"}, 32'(b_level), q.size());
        chk({tag, "_valid"}, 32'(a_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk({tag, "_data"}, 32'(a_data), 32'(q[0]));
        chk({tag, "_ovf_a"}, 32'(a_ovf), 32'(m_ovf));
        chk({tag, "_ovf_b"}, 32'(b_ovf), 32'(m_ovf));
        chk({tag, "_err_a"}, 32'(a_err), m_err_a);
        chk({tag, "_err_b"}, 32'(b_err), m_err_b);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_err_a = 0;
        m_err_b = 0;
    endtask

    // One receiver frame: present the event, hold it for 'hold' ack cycles, then release.
    task automatic rx_event(input logic [7:0] d, input logic av, input logic er,
                            input logic rdy, input logic cl, input int hold);
        @(negedge clk);
        rx_data  = d;
        rx_avail = av;
        rx_err   = er;
        ready    = rdy;
        clr      = cl;
        cap_edge = edge_n + 1;
        if (rdy && q.size() > 0) begin
            chk("pop_head", 32'(a_data), 32'(q[0]));
            void'(q.pop_front());
        end
        if (cl) begin
            m_ovf   = 1'b0;
            m_err_a = 0;
            m_err_b = 0;
        end else if (er) begin
            if (m_err_a < 255) m_err_a++;
            if (m_err_b < 3) m_err_b++;
        end
        if (av && !er) begin
            if (q.size() < DEPTH) q.push_back(d);
            else if (!cl) m_ovf = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            ready = 1'b0;
            clr   = 1'b0;
            chk("ack_high_a", 32'(a_ack), 1);
            chk("ack_high_b", 32'(b_ack), 1);
        end
        rx_avail = 1'b0;
        rx_err   = 1'b0;
        @(negedge clk);
        chk("ack_low", 32'(a_ack), 0);
        check_state("evt");
    endtask

    task automatic pop_one();
        @(negedge clk);
        if (q.size() > 0) begin
            chk("pop_valid", 32'(a_valid), 1);
            chk("pop_data", 32'(a_data), 32'(q[0]));
            void'(q.pop_front());
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check_state("pop");
    endtask

    task automatic drain();
        int n;
        n = q.size();
        for (int i = 0; i < n; i++) pop_one();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int p0;
        int kind;
        // reset values
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(a_ack), 0);
        chk("rst_idle", 32'(a_idle), 0);
        chk("rst_data", 32'(a_data), 0);
        check_state("rst");
        rst_n = 1'b1;

        // no idle pulse before the first byte
        repeat (30) @(negedge clk);
        chk("idle_before_byte", idle_pulses, 0);

        // single byte, ack held for three cycles, captured once
        rx_event(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 3);
        drain();

        // nine bytes into eight entries
        for (int i = 1; i <= 9; i++) rx_event(8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1);
        chk("full_level", 32'(a_level), 8);
        chk("full_ovf", 32'(a_ovf), 1);
        drain();

        // error counting, clear priority, saturation at ERR_W=2
        for (int i = 0; i < 3; i++) rx_event(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        chk("err3", 32'(a_err), 3);
        rx_event(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        chk("err_clr", 32'(a_err), 0);
        for (int i = 0; i < 5; i++) rx_event(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        chk("err5_a", 32'(a_err), 5);
        chk("err5_b_sat", 32'(b_err), 3);

        // full FIFO with simultaneous pop and push
        for (int i = 0; i < 8; i++) rx_event(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1);
        rx_event(8'h18, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        chk("popush_level", 32'(a_level), 8);
        chk("popush_ovf", 32'(a_ovf), 0);
        drain();

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            rx_event(8'($urandom), kind != 2, kind >= 2, 1'($urandom),
                     $urandom_range(0, 9) == 0, $urandom_range(1, 2));
            if ($urandom_range(0, 2) == 0) pop_one();
        end
        drain();

        // reset in the middle of a handshake; pending byte recaptured once
        rx_event(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        @(negedge clk);
        rx_data  = 8'hA5;
        rx_avail = 1'b1;
        @(negedge clk);
        chk("midrst_ack_before", 32'(a_ack), 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_ack", 32'(a_ack), 0);
        chk("midrst_ack_b", 32'(b_ack), 0);
        chk("midrst_data", 32'(a_data), 0);
        check_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(8'hA5);
        @(negedge clk);
        chk("recap_ack", 32'(a_ack), 1);
        rx_avail = 1'b0;
        @(negedge clk);
        chk("recap_ack_low", 32'(a_ack), 0);
        check_state("recap");
        repeat (3) @(negedge clk);
        check_state("recap_once");
        drain();

        // idle timeout after a single byte
        do_reset();
        p0 = idle_pulses;
        repeat (30) @(negedge clk);
        chk("idle_none_after_rst", idle_pulses - p0, 0);
        rx_event(8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        p0 = cap_edge;
        repeat (40) @(negedge clk);
`ifdef UART_RX_CTRL_TIMEOUT_EN
        chk("idle_once", idle_pulses, 1);
        chk("idle_delay", pulse_edge - p0, IDLE);
`else
        chk("idle_tied", idle_pulses, 0);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
